// File: rtl/freq_hill_climber_pkg.sv
// ============================================================================
// freq_hill_climber_pkg : shared types and default limits for the hill climber
// Revision: 1.0
// ============================================================================
`default_nettype none

package freq_hill_climber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_EVAL    = 2'd3
    } state_t;

    localparam int CURR_W = 12;
    localparam int TMR_W  = 20;

    localparam logic [15:0] DEF_F_START = 16'd1000;
    localparam logic [15:0] DEF_F_MIN   = 16'd800;
    localparam logic [15:0] DEF_F_MAX   = 16'd1200;
    localparam logic [15:0] DEF_STEP    = 16'd5;

    localparam logic [TMR_W-1:0] DEF_SETTLE_CYCLES = 20'd10000;
    // Window length shared with the mean-current measurement stage.
    localparam logic [TMR_W-1:0] DEF_MEAS_CYCLES   = 20'h9C40;

endpackage

`default_nettype wire

// File: rtl/freq_hill_climber_phase_timer.sv
// ============================================================================
// freq_hill_climber_phase_timer : 20-bit phase counter with clear and terminal count
// Revision: 1.0
// ============================================================================
`default_nettype none

module freq_hill_climber_phase_timer
    import freq_hill_climber_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TMR_W-1:0] limit_i,
    output logic             tc_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i - TMR_W'(1));

endmodule

`default_nettype wire

// File: rtl/freq_hill_climber.sv
// ============================================================================
// freq_hill_climber : perturb-and-observe drive frequency tracker
// Revision: 1.0
// ============================================================================
`default_nettype none

module freq_hill_climber
    import freq_hill_climber_pkg::*;
#(
    parameter int               FREQ_W        = 16,
    parameter logic [FREQ_W-1:0] F_START      = DEF_F_START,
    parameter logic [FREQ_W-1:0] F_MIN        = DEF_F_MIN,
    parameter logic [FREQ_W-1:0] F_MAX        = DEF_F_MAX,
    parameter logic [FREQ_W-1:0] STEP         = DEF_STEP,
    parameter logic [TMR_W-1:0] SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [TMR_W-1:0] MEAS_CYCLES   = DEF_MEAS_CYCLES,
    parameter int               LOCK_REV      = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic [CURR_W-1:0] mean_curr,
    output logic              measure,
    output logic [FREQ_W-1:0] freq_word,
    output logic [CURR_W-1:0] last_mean,
    output logic              step_done,
    output logic              locked
);

    localparam int REV_W = $clog2(LOCK_REV + 1);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(LOCK_REV);

    state_t              state_q, state_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [CURR_W-1:0]   last_mean_q, last_mean_d;
    logic [CURR_W-1:0]   prev_mean_q, prev_mean_d;
    logic                step_done_q, step_done_d;
    logic                locked_q, locked_d;
    logic                dir_q, dir_d;
    logic [REV_W-1:0]    rev_cnt_q, rev_cnt_d;

    logic                tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0]    tmr_limit;

    logic                cmp_rev, dir_cmp, forced;
    logic [FREQ_W:0]     up_sum, dn_floor;

    freq_hill_climber_phase_timer u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (tmr_clr | ~swiptAlive),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc)
    );

    // Step arithmetic is one bit wider than the word so neither edge can wrap.
    assign up_sum   = {1'b0, freq_q} + {1'b0, STEP};
    assign dn_floor = {1'b0, F_MIN} + {1'b0, STEP};
    assign cmp_rev  = !(mean_curr > prev_mean_q);
    assign dir_cmp  = dir_q ^ cmp_rev;

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        last_mean_d = last_mean_q;
        prev_mean_d = prev_mean_q;
        step_done_d = 1'b0;
        locked_d    = locked_q;
        dir_d       = dir_q;
        rev_cnt_d   = rev_cnt_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        tmr_limit   = SETTLE_CYCLES;
        forced      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_limit = SETTLE_CYCLES;
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_d = ST_MEASURE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_MEASURE: begin
                tmr_limit = MEAS_CYCLES;
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_d = ST_EVAL;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_EVAL: begin
                tmr_clr     = 1'b1;
                state_d     = ST_SETTLE;
                step_done_d = 1'b1;
                last_mean_d = mean_curr;
                prev_mean_d = mean_curr;
                if (dir_cmp) begin
                    if (up_sum > {1'b0, F_MAX}) begin
                        freq_d = F_MAX;
                        dir_d  = 1'b0;
                        forced = 1'b1;
                    end else begin
                        freq_d = up_sum[FREQ_W-1:0];
                        dir_d  = 1'b1;
                    end
                end else begin
                    if ({1'b0, freq_q} < dn_floor) begin
                        freq_d = F_MIN;
                        dir_d  = 1'b1;
                        forced = 1'b1;
                    end else begin
                        freq_d = freq_q - STEP;
                        dir_d  = 1'b0;
                    end
                end
                // A compare reversal and a clamp flip in the same EVAL count once.
                if ((cmp_rev || forced) && (rev_cnt_q != REV_MAX)) begin
                    rev_cnt_d = rev_cnt_q + REV_W'(1);
                end
                if (rev_cnt_d == REV_MAX) begin
                    locked_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst || !swiptAlive) begin
            state_q     <= ST_IDLE;
            freq_q      <= F_START;
            last_mean_q <= '0;
            prev_mean_q <= '0;
            step_done_q <= 1'b0;
            locked_q    <= 1'b0;
            dir_q       <= 1'b1;
            rev_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            last_mean_q <= last_mean_d;
            prev_mean_q <= prev_mean_d;
            step_done_q <= step_done_d;
            locked_q    <= locked_d;
            dir_q       <= dir_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    assign measure   = (state_q == ST_MEASURE);
    assign freq_word = freq_q;
    assign last_mean = last_mean_q;
    assign step_done = step_done_q;
    assign locked    = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_hill_climber.sv
// ============================================================================
// tb_freq_hill_climber : directed scoreboard bench for freq_hill_climber
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_freq_hill_climber;

    typedef struct packed {
        logic [15:0] f;
        logic [11:0] m;
        logic        lk;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        swiptAlive = 1'b1;
    logic [11:0] mean_curr = 12'd0;
    logic        measure;
    logic [15:0] freq_word;
    logic [11:0] last_mean;
    logic        step_done;
    logic        locked;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    freq_hill_climber #(
        .FREQ_W        (16),
        .F_START       (16'd100),
        .F_MIN         (16'd80),
        .F_MAX         (16'd120),
        .STEP          (16'd5),
        .SETTLE_CYCLES (20'd4),
        .MEAS_CYCLES   (20'd8),
        .LOCK_REV      (4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .mean_curr  (mean_curr),
        .measure    (measure),
        .freq_word  (freq_word),
        .last_mean  (last_mean),
        .step_done  (step_done),
        .locked     (locked)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every step_done pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (nrst && swiptAlive && step_done) begin
            if (q.size() == 0) begin
                chk("unexpected_step_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("freq_word", int'(freq_word), int'(e.f));
                chk("last_mean", int'(last_mean), int'(e.m));
                chk("locked", int'(locked), int'(e.lk));
            end
        end
    end

    task automatic check_cleared(input string tag);
        chk({tag, "_freq"}, int'(freq_word), 100);
        chk({tag, "_measure"}, int'(measure), 0);
        chk({tag, "_last_mean"}, int'(last_mean), 0);
        chk({tag, "_step_done"}, int'(step_done), 0);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    // Called on the negedge where the clear is released (DUT in IDLE).
    task automatic restart_timing(input logic [11:0] m, input logic [15:0] f, input string tag);
        exp_t e;
        mean_curr = m;
        e.f = f; e.m = m; e.lk = 1'b0;
        q.push_back(e);
        for (int i = 0; i <= 14; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_measure"}, int'(measure), (i >= 5 && i <= 12) ? 1 : 0);
            chk({tag, "_step_done"}, int'(step_done), (i == 14) ? 1 : 0);
            if (i <= 13) chk({tag, "_freq_hold"}, int'(freq_word), 100);
        end
    endtask

    task automatic run_iter(input logic [11:0] m, input logic [15:0] f, input logic lk);
        exp_t e;
        bit   seen;
        mean_curr = m;
        e.f = f; e.m = m; e.lk = lk;
        q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (step_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("step_done_timeout", 0, 1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        nrst = 1'b0;
        mean_curr = 12'd0;
        @(negedge clk);
        check_cleared(tag);
        nrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        // Reset and first-iteration timing
        do_reset("reset");
        restart_timing(12'd100, 16'd105, "timing");

        // Climb
        do_reset("reset_climb");
        restart_timing(12'd100, 16'd105, "timing_climb");
        run_iter(12'd200, 16'd110, 1'b0);
        run_iter(12'd300, 16'd115, 1'b0);

        // Peak reversal, then equal value reverses again
        do_reset("reset_peak");
        restart_timing(12'd100, 16'd105, "timing_peak");
        run_iter(12'd200, 16'd110, 1'b0);
        run_iter(12'd150, 16'd105, 1'b0);
        run_iter(12'd150, 16'd110, 1'b0);

        // Upper clamp
        do_reset("reset_clamp_hi");
        restart_timing(12'd10, 16'd105, "timing_clamp_hi");
        run_iter(12'd20, 16'd110, 1'b0);
        run_iter(12'd30, 16'd115, 1'b0);
        run_iter(12'd40, 16'd120, 1'b0);
        run_iter(12'd50, 16'd120, 1'b0);
        run_iter(12'd60, 16'd115, 1'b0);
        run_iter(12'd70, 16'd110, 1'b0);

        // Zero first mean reverses; lower clamp
        do_reset("reset_clamp_lo");
        mean_curr = 12'd0;
        restart_timing(12'd0, 16'd95, "timing_clamp_lo");
        run_iter(12'd1, 16'd90, 1'b0);
        run_iter(12'd2, 16'd85, 1'b0);
        run_iter(12'd3, 16'd80, 1'b0);
        run_iter(12'd4, 16'd80, 1'b0);
        run_iter(12'd5, 16'd85, 1'b0);

        // Lock after four reversals, held afterwards
        do_reset("reset_lock");
        restart_timing(12'd300, 16'd105, "timing_lock");
        run_iter(12'd100, 16'd100, 1'b0);
        run_iter(12'd300, 16'd95, 1'b0);
        run_iter(12'd100, 16'd100, 1'b0);
        run_iter(12'd300, 16'd105, 1'b0);
        run_iter(12'd100, 16'd100, 1'b0);
        run_iter(12'd300, 16'd95, 1'b0);
        run_iter(12'd100, 16'd100, 1'b1);
        run_iter(12'd300, 16'd105, 1'b1);
        run_iter(12'd100, 16'd100, 1'b1);
        run_iter(12'd300, 16'd95, 1'b1);

        // Mid-window abort via swiptAlive
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (measure) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("measure_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("abort_measure_before", int'(measure), 1);
        swiptAlive = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        swiptAlive = 1'b1;
        restart_timing(12'd100, 16'd105, "timing_restart");

        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
